// File: rtl/mma_result_serializer.sv
// Captures one M x N MMA result matrix, narrows each element to OUT_P bits, and streams it
// out one row per beat; row 0 appears 1 cycle after accept, rows are held while out_ready_i is low.
module mma_result_serializer #(
    parameter int M      = 8,
    parameter int N      = 4,
    parameter int P      = 8,
    parameter int OUT_P  = 16,
    parameter int SAT_EN = 1,
    parameter int IDXW   = (M > 1) ? $clog2(M) : 1
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        in_valid_i,
    output logic                        in_ready_o,
    input  logic signed [4*P-1:0]       d_i [M][N],
    output logic                        out_valid_o,
    input  logic                        out_ready_i,
    output logic signed [OUT_P-1:0]     out_row_o [N],
    output logic        [IDXW-1:0]      out_idx_o,
    output logic                        out_last_o,
    output logic                        out_sat_o
);
    localparam int IW = 4 * P;
    // Clamp bounds in input precision; for OUT_P == IW the compares can never fire.
    localparam logic signed [IW-1:0] C_MAX = (IW'(1) << (OUT_P - 1)) - IW'(1);
    localparam logic signed [IW-1:0] C_MIN = ~C_MAX;

    typedef enum logic {S_IDLE, S_SEND} state_t;

    state_t                   r_state;
    logic [IDXW-1:0]          r_cnt;
    logic signed [OUT_P-1:0]  r_hold [M][N];
    logic                     r_sat  [M];

    logic signed [OUT_P-1:0]  w_nar  [M][N];
    logic                     w_rsat [M];
    logic                     w_last;
    logic                     w_rdy;
    logic                     w_take;

    function automatic logic f_clip(input logic signed [IW-1:0] d);
        return (SAT_EN != 0) && ((d > C_MAX) || (d < C_MIN));
    endfunction

    function automatic logic signed [OUT_P-1:0] f_narrow(input logic signed [IW-1:0] d);
        if (f_clip(d))
            return d[IW-1] ? C_MIN[OUT_P-1:0] : C_MAX[OUT_P-1:0];
        return d[OUT_P-1:0];
    endfunction

    always_comb begin
        for (int r = 0; r < M; r++) begin
            w_rsat[r] = 1'b0;
            for (int c = 0; c < N; c++) begin
                w_nar[r][c] = f_narrow(d_i[r][c]);
                w_rsat[r]   = w_rsat[r] | f_clip(d_i[r][c]);
            end
        end
    end

    assign w_last     = (r_cnt == IDXW'(M - 1));
    // A new matrix may land in the same cycle the final row is handed off.
    assign w_rdy      = (r_state == S_IDLE) || (out_ready_i && w_last);
    assign w_take     = in_valid_i && w_rdy;
    assign in_ready_o = !rst_i && w_rdy;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (in_valid_i)
                        r_state <= S_SEND;
                end
                S_SEND: begin
                    if (out_ready_i) begin
                        if (w_last) begin
                            r_cnt <= '0;
                            if (!in_valid_i)
                                r_state <= S_IDLE;
                        end else begin
                            r_cnt <= r_cnt + IDXW'(1);
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Payload storage needs no reset: outputs are masked outside SEND.
    always_ff @(posedge clk_i) begin
        if (w_take) begin
            for (int r = 0; r < M; r++) begin
                r_sat[r] <= w_rsat[r];
                for (int c = 0; c < N; c++)
                    r_hold[r][c] <= w_nar[r][c];
            end
        end
    end

    assign out_valid_o = (r_state == S_SEND);
    assign out_idx_o   = r_cnt;
    assign out_last_o  = out_valid_o && w_last;
    assign out_sat_o   = out_valid_o && r_sat[r_cnt];

    always_comb begin
        for (int c = 0; c < N; c++)
            out_row_o[c] = out_valid_o ? r_hold[r_cnt][c] : '0;
    end
endmodule

// File: doc/mma_result_serializer.md
Name: mma_result_serializer

Overview:
- Output-side stage placed directly downstream of the synthesis top-level matrix multiply-accumulate block.
- Consumes one full M x N result matrix D (4P-bit signed elements) through a valid/ready handshake.
- Narrows each element to OUT_P bits, by saturation or truncation.
- Streams the matrix out one row per beat, with row index and last flag, for a narrow writeback/AXI-stream path.

Parameters:
- M, 8, rows of D (number of beats per matrix); M >= 1
- N, 4, columns of D (elements per beat); N >= 1
- P, 8, base precision; input element width is 4*P
- OUT_P, 16, output element width; 1 <= OUT_P <= 4*P
- SAT_EN, 1, 1 = signed saturation on narrowing, 0 = truncation (keep OUT_P LSBs)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-high reset
- in_valid_i  in  1  D matrix valid
- in_ready_o  out  1  block can accept a matrix this cycle
- d_i  in  signed [4*P-1:0] [M][N]  result matrix from MMA output buffer
- out_valid_o  out  1  output row valid
- out_ready_i  in  1  downstream accepts row
- out_row_o  out  signed [OUT_P-1:0] [N]  current row, element c = column c
- out_idx_o  out  $clog2(M) (min 1)  row index of current beat
- out_last_o  out  1  current beat is row M-1
- out_sat_o  out  1  any element of current row was clamped (always 0 when SAT_EN=0 or OUT_P=4*P)

Behaviour:
- States: IDLE (no matrix held), SEND (matrix held, rows being emitted).
- Reset:
  - While rst_i is high: state=IDLE, out_valid_o=0, out_idx_o=0, out_last_o=0, out_sat_o=0, out_row_o=0, in_ready_o=0.
  - Reset takes effect asynchronously, including mid-operation; the held matrix is discarded.
  - First cycle after release: in_ready_o=1.
- in_ready_o (combinational) = !rst_i && (state==IDLE || (out_valid_o && out_ready_i && out_last_o)).
- Accept:
  - On in_valid_i && in_ready_o, all M*N elements are narrowed and registered into the holding array.
  - Row counter is set to 0; state becomes SEND.
  - out_valid_o=1 from the next cycle. Latency is 1 cycle from accept to row 0.
- Narrowing, applied per element at capture:
  - SAT_EN=1: values > 2^(OUT_P-1)-1 become 2^(OUT_P-1)-1; values < -2^(OUT_P-1) become -2^(OUT_P-1); a per-row sat bit is stored with each row.
  - SAT_EN=0: result is d[OUT_P-1:0].
  - OUT_P=4*P: pass-through.
- Emit, in SEND:
  - out_row_o, out_idx_o, out_last_o and out_sat_o reflect the current row counter.
  - All outputs are held stable while out_valid_o && !out_ready_i.
  - Each handshake advances the counter by 1.
- Last-row handshake (counter = M-1):
  - If in_valid_i is high in the same cycle, the new matrix is captured, the counter wraps to 0, and out_valid_o stays 1 (back-to-back, no bubble).
  - Otherwise state=IDLE and out_valid_o=0 next cycle.
- in_valid_i while in SEND and not on the last handshake: ignored; in_ready_o=0, so the upstream holds.
- M=1: every beat has out_last_o=1, and in_ready_o follows out_ready_i while SEND.
- out_valid_o never drops in SEND without a last-row handshake or reset.
- No combinational path from d_i to any output.

Test Plan (M=8, N=4, P=8, OUT_P=16, SAT_EN=1 unless stated):
1. Reset sequencing:
   - Stimulus: assert rst_i asynchronously mid-cycle.
   - Response: out_valid_o=0 and in_ready_o=0 immediately; in_ready_o=1 on the first cycle after release.
2. Single matrix, D[r][c]=16r+c, out_ready_i=1:
   - out_valid_o rises 1 cycle after accept.
   - 8 consecutive beats with out_idx_o 0..7; beat 5 carries row {80,81,82,83}.
   - out_last_o=1 only at idx 7; in_ready_o=0 during beats 0..6 and 1 during beat 7.
3. Backpressure, out_ready_i pattern 1,0,0,1,0,1...:
   - Row data, idx and last are held unchanged during stalls.
   - Exactly 8 beats, none skipped or duplicated.
4. Back-to-back:
   - Stimulus: second matrix (all elements -5) presented during the row-7 handshake.
   - Response: accepted in that cycle; the next cycle shows idx 0 = {-5,-5,-5,-5}; 16 beats in 16 cycles.
5. Saturation:
   - Stimulus: row 2 = {40000, -40000, 32767, -32768}.
   - SAT_EN=1: output {32767, -32768, 32767, -32768}, out_sat_o=1 on row 2 only.
   - SAT_EN=0: output {-25536, 25536, 32767, -32768}, out_sat_o=0.
6. Reset mid-stream:
   - Stimulus: pulse rst_i after the row-3 handshake, then send a new matrix.
   - Response: out_valid_o drops immediately; the new matrix emits starting at idx 0 with its own data, and no old rows appear.
